sonic_rx_ring_drain: RTL and testbench



---
 rtl/sonic_rx_ring_drain_if.sv | 23 ++
 rtl/sonic_rx_ring_drain.sv | 168 ++++++++++++++++
 tb/tb_sonic_rx_ring_drain.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sonic_rx_ring_drain_if.sv
// Ring-read and output-stream signals of the rx ring drain stage.
// master = drain side (issues reads, drives the stream); slave = ring + downstream packer.
interface sonic_rx_ring_drain_if #(
  parameter int unsigned PTR_W  = 14,
  parameter int unsigned DATA_W = 128
);
  logic [PTR_W-2:0]  rd_address;
  logic              dma_rdreq;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rd_address, dma_rdreq, out_data, out_valid,
    input  data_in, out_ready
  );

  modport slave (
    input  rd_address, dma_rdreq, out_data, out_valid,
    output data_in, out_ready
  );
endinterface

// File: rtl/sonic_rx_ring_drain.sv
// Drains the rx ring behind a credit-limited FIFO onto a valid/ready stream.
// Defining SONIC_RX_DRAIN_STATS_EN adds word/stall/max-avail statistics outputs.
module sonic_rx_ring_drain #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 14
) (
  input  logic                  i_rd_clock,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [PTR_W-1:0]      i_rx_ring_wptr,
  sonic_rx_ring_drain_if.master bus,
  output logic [PTR_W-1:0]      o_rx_ring_rptr,
`ifdef SONIC_RX_DRAIN_STATS_EN
  output logic [31:0]           o_stat_words,
  output logic [31:0]           o_stat_stall,
  output logic [PTR_W-1:0]      o_stat_max_avail,
`endif
  output logic                  o_busy
);
  localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e            r_state;
  logic              r_busy;
  logic [PTR_W-1:0]  r_issue_ptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [RD_LAT-1:0] r_vld_sr;
  logic [127:0]      r_mem [FIFO_DEPTH];
  logic [IdxW-1:0]   r_wr_idx;
  logic [IdxW-1:0]   r_rd_idx;
  logic [CntW-1:0]   r_count;

  logic [PTR_W-1:0]  w_avail;
  logic [CntW-1:0]   w_inflight;
  logic [CntW:0]     w_used;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_pending;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      w_inflight = w_inflight + CntW'(r_vld_sr[i]);
    end
  end

  // Credit counts reads still in the pipe as well as words already buffered,
  // so a returning read always finds a free FIFO slot.
  assign w_avail   = i_rx_ring_wptr - r_issue_ptr;
  assign w_used    = {1'b0, w_inflight} + {1'b0, r_count};
  assign w_issue   = (r_state == StRun) && i_enable && (w_avail != '0) &&
                     (w_used < (CntW + 1)'(FIFO_DEPTH));
  assign w_push    = r_vld_sr[RD_LAT-1];
  assign w_pop     = (r_count != '0) && bus.out_ready;
  assign w_pending = (w_inflight != '0) || (r_count != '0);

  assign bus.dma_rdreq  = w_issue;
  assign bus.rd_address = r_issue_ptr[PTR_W-2:0];
  assign bus.out_valid  = (r_count != '0);
  assign bus.out_data   = r_mem[r_rd_idx];
  assign o_rx_ring_rptr = r_rptr;
  assign o_busy         = r_busy;

  always_ff @(posedge i_rd_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_enable) begin
            r_state <= StRun;
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          if (!i_enable) begin
            if (w_pending) begin
              r_state <= StFlush;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end
        end
        StFlush: begin
          if (i_enable) begin
            r_state <= StRun;
          end else if (!w_pending) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_rd_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_issue_ptr <= '0;
      r_rptr      <= '0;
      r_vld_sr    <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_count     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_issue_ptr <= r_issue_ptr + PTR_W'(1);
      end
      r_vld_sr[0] <= w_issue;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
      if (w_push) begin
        r_mem[r_wr_idx] <= bus.data_in;
        r_wr_idx        <= r_wr_idx + IdxW'(1);
      end
      if (w_pop) begin
        r_rd_idx <= r_rd_idx + IdxW'(1);
        r_rptr   <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SONIC_RX_DRAIN_STATS_EN
  logic [31:0]      r_stat_words;
  logic [31:0]      r_stat_stall;
  logic [PTR_W-1:0] r_stat_max_avail;

  always_ff @(posedge i_rd_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stat_words     <= '0;
      r_stat_stall     <= '0;
      r_stat_max_avail <= '0;
    end else begin
      if (w_pop) begin
        r_stat_words <= r_stat_words + 32'd1;
      end
      if (bus.out_valid && !bus.out_ready && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
      if (w_avail > r_stat_max_avail) begin
        r_stat_max_avail <= w_avail;
      end
    end
  end

  assign o_stat_words     = r_stat_words;
  assign o_stat_stall     = r_stat_stall;
  assign o_stat_max_avail = r_stat_max_avail;
`endif
endmodule

// File: tb/tb_sonic_rx_ring_drain.sv
// Scoreboard bench for sonic_rx_ring_drain: a ring model feeds reads back after RD_LAT
// cycles, the producer side queues the expected words/addresses, a monitor pops and compares.
module tb_sonic_rx_ring_drain;
  localparam int unsigned PTR_W      = 14;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             busy;
`ifdef SONIC_RX_DRAIN_STATS_EN
  logic [31:0]      stat_words;
  logic [31:0]      stat_stall;
  logic [PTR_W-1:0] stat_max_avail;
`endif

  sonic_rx_ring_drain_if #(.PTR_W(PTR_W), .DATA_W(128)) bus ();

  sonic_rx_ring_drain #(
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PTR_W     (PTR_W)
  ) dut (
    .i_rd_clock      (clk),
    .i_reset_n       (rst_n),
    .i_enable        (enable),
    .i_rx_ring_wptr  (wptr),
    .bus             (bus),
    .o_rx_ring_rptr  (rptr),
`ifdef SONIC_RX_DRAIN_STATS_EN
    .o_stat_words    (stat_words),
    .o_stat_stall    (stat_stall),
    .o_stat_max_avail(stat_max_avail),
`endif
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [127:0]     ring [8192];
  logic [127:0]     exp_data [$];
  logic [12:0]      exp_addr [$];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] m_rptr;
  int               m_out;
  int               n_issue = 0;
  int               n_pop   = 0;
  logic             cap_req;
  logic [12:0]      cap_addr;
  logic             hold_v;
  logic [127:0]     hold_d;
  logic             pipe_v [RD_LAT];
  logic [12:0]      pipe_a [RD_LAT];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ring read port: a request seen in cycle t returns ring data during cycle t+RD_LAT.
  initial begin
    bus.data_in = '0;
    for (int i = 0; i < int'(RD_LAT); i++) pipe_v[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < int'(RD_LAT); i++) pipe_v[i] = 1'b0;
      end else begin
        for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
          pipe_v[i] = pipe_v[i-1];
          pipe_a[i] = pipe_a[i-1];
        end
        pipe_v[0] = cap_req;
        pipe_a[0] = cap_addr;
      end
      #1;
      bus.data_in = pipe_v[RD_LAT-1] ? ring[pipe_a[RD_LAT-1]] : {4{$urandom}};
    end
  end

  // Monitor: compares every issued address and every accepted word against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      cap_req = 1'b0;
      hold_v  = 1'b0;
      m_rptr  = '0;
      m_out   = 0;
      exp_data.delete();
      exp_addr.delete();
    end else begin
      cap_req  = bus.dma_rdreq;
      cap_addr = bus.rd_address;
      check("rptr", rptr, m_rptr);
      if (hold_v) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_data", bus.out_data, hold_d);
      end
      if (bus.dma_rdreq) begin
        n_issue++;
        m_out++;
        if (exp_addr.size() == 0) check("rdreq_expected", 0, 1);
        else check("rd_address", bus.rd_address, exp_addr.pop_front());
        check("credit", m_out <= int'(FIFO_DEPTH), 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        m_out--;
        m_rptr++;
        if (exp_data.size() == 0) check("pop_expected", 0, 1);
        else check("out_data", bus.out_data, exp_data.pop_front());
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic produce(input int n);
    logic [127:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      ring[wp[12:0]] = w;
      exp_data.push_back(w);
      exp_addr.push_back(wp[12:0]);
      wp = wp + 14'd1;
    end
    wptr = wp;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_data.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_done", exp_data.size(), 0);
    tick();
  endtask

  initial begin
    int seen;
    int pops;
    int n;
    rst_n = 1'b0;
    enable = 1'b0;
    wp = '0;
    wptr = '0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_rdreq", bus.dma_rdreq, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_rptr", rptr, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    enable = 1'b1;

    // Empty ring: running but nothing to do.
    seen = n_issue;
    repeat (20) tick();
    check("idle_busy", busy, 1);
    check("idle_valid", bus.out_valid, 0);
    check("idle_rptr", rptr, 0);
    check("idle_issues", n_issue - seen, 0);

    // Single word latency.
    bus.out_ready = 1'b1;
    produce(1);
    @(negedge clk);
    check("lat_rdreq", bus.dma_rdreq, 1);
    check("lat_addr", bus.rd_address, 0);
    @(negedge clk);
    check("lat_valid_t1", bus.out_valid, 0);
    @(negedge clk);
    check("lat_valid_t2", bus.out_valid, 0);
    @(negedge clk);
    check("lat_valid_t3", bus.out_valid, 1);
    check("lat_data", bus.out_data, ring[0]);
    @(negedge clk);
    check("lat_rptr_t4", rptr, 1);

    // Backpressure: credit caps issues at FIFO_DEPTH.
    tick();
    bus.out_ready = 1'b0;
    seen = n_issue;
    produce(10);
    repeat (12) tick();
    check("cap_issues", n_issue - seen, FIFO_DEPTH);
    check("cap_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    drain(60);
    check("burst_issues", n_issue - seen, 10);
    check("burst_rptr", rptr, 11);

    // Random traffic, ready and enable.
    for (int it = 0; it < 400; it++) begin
      tick();
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if (exp_data.size() < 40 && $urandom_range(0, 2) == 0) produce($urandom_range(1, 5));
    end
    enable = 1'b1;
    bus.out_ready = 1'b1;
    drain(400);
    check("rand_rptr", rptr, wp);

    // Walk the pointers up to just below the 14-bit wrap, then cross it.
    while (wp != 14'd16380) begin
      tick();
      produce(1);
    end
    drain(100);
    check("prewrap_rptr", rptr, 16380);
    seen = n_issue;
    tick();
    produce(6);
    drain(60);
    check("wrap_issues", n_issue - seen, 6);
    check("wrap_rptr", rptr, 2);

    // Drop enable with three reads outstanding.
    tick();
    seen = n_issue;
    pops = n_pop;
    produce(8);
    n = 0;
    while (n_issue - seen < 3 && n < 20) begin
      tick();
      n++;
    end
    enable = 1'b0;
    tick();
    check("flush_busy", busy, 1);
    repeat (8) tick();
    check("flush_issues", n_issue - seen, 3);
    check("flush_pops", n_pop - pops, 3);
    check("flush_idle", busy, 0);
    enable = 1'b1;
    drain(60);
    check("resume_issues", n_issue - seen, 8);
    check("resume_rptr", rptr, wp);

    // Asynchronous reset mid-burst with three words buffered and a read being issued.
    tick();
    bus.out_ready = 1'b0;
    produce(3);
    repeat (6) tick();
    produce(1);
    #2;
    check("prerst_rdreq", bus.dma_rdreq, 1);
    check("prerst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_rdreq", bus.dma_rdreq, 0);
    check("arst_rptr", rptr, 0);
    check("arst_busy", busy, 0);
    check("arst_data", bus.out_data, 0);
    wp = '0;
    wptr = '0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    tick();
    produce(2);
    drain(30);
    check("post_rst_rptr", rptr, 2);
`ifdef SONIC_RX_DRAIN_STATS_EN
    check("stat_words", stat_words, 2);
    check("stat_max_avail", stat_max_avail, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
